dec: RTL and testbench

DEC -- requirements
Module: dec

---
 rtl/dec.sv | 182 ++++++++++++++++++
 tb/tb_dec.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec.sv
// Level-crossing lamp controller.
// A 4-word parameter RAM holds timing sets {PRE, T_RY, T_R, T_Y}. On a train
// request in GREEN the set selected by DIVSEL is latched, and the lamps run
// YELLOW -> RED -> RED_YELLOW -> GREEN. Each phase lasts N*PRE clocks. RED is
// held while the train request stays high.
// Ports:
//   clk, clrn                 clock, synchronous active-low reset
//   ctl_wr/rd/addr/wrdata     register port (0 = CTRL.EN, 1 = DIVSEL.SEL)
//   ctl_rddata                combinational read data, 0 when ctl_rd=0
//   ram_wr/addr/wrdata        parameter RAM write port
//   train                     train-present request
//   red, yellow, green        registered lamp outputs
module dec (
    input  logic        clk,
    input  logic        clrn,
    input  logic        ctl_wr,
    input  logic        ctl_rd,
    input  logic        ctl_addr,
    input  logic [31:0] ctl_wrdata,
    output logic [31:0] ctl_rddata,
    input  logic        ram_wr,
    input  logic [1:0]  ram_addr,
    input  logic [31:0] ram_wrdata,
    input  logic        train,
    output logic        red,
    output logic        yellow,
    output logic        green
);

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned SW    = 2;

    typedef struct packed {
        logic [CW-1:0] pre;
        logic [CW-1:0] t_ry;
        logic [CW-1:0] t_r;
        logic [CW-1:0] t_y;
    } param_t;

    typedef enum logic [2:0] {
        S_OFF,
        S_GREEN,
        S_YELLOW,
        S_RED,
        S_RED_YELLOW
    } state_t;

    logic          en_q, en_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [DW-1:0] ram_q [DEPTH];
    logic [DW-1:0] ram_d [DEPTH];
    param_t        param_q, param_d;
    logic [CW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [2:0]    lamp_q, lamp_d;

    logic [CW-1:0] pre_eff;
    logic [CW-1:0] n_eff;
    logic          tick;
    logic          last;
    logic          unused_wrdata;

    assign unused_wrdata = ^ctl_wrdata[DW-1:SW];

    // Next-state, counter and register-file update logic
    always_comb begin
        en_d    = en_q;
        sel_d   = sel_q;
        ram_d   = ram_q;
        param_d = param_q;
        presc_d = presc_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        lamp_d  = lamp_q;

        // Zero durations behave as 1
        pre_eff = (param_q.pre == '0) ? CW'(1) : param_q.pre;
        case (state_q)
            S_RED:        n_eff = param_q.t_r;
            S_RED_YELLOW: n_eff = param_q.t_ry;
            default:      n_eff = param_q.t_y;
        endcase
        if (n_eff == '0) begin
            n_eff = CW'(1);
        end
        tick = (presc_q == pre_eff - CW'(1));
        last = tick && (cnt_q == n_eff - CW'(1));

        if (ctl_wr) begin
            if (ctl_addr) begin
                sel_d = ctl_wrdata[SW-1:0];
            end else begin
                en_d = ctl_wrdata[0];
            end
        end
        if (ram_wr) begin
            ram_d[ram_addr] = ram_wrdata;
        end

        if (!en_q) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF:        state_d = S_GREEN;
                S_GREEN: begin
                    if (train) begin
                        state_d = S_YELLOW;
                        param_d = param_t'(ram_q[sel_q]);
                    end
                end
                S_YELLOW:     if (last) state_d = S_RED;
                S_RED:        if (!train && last) state_d = S_RED_YELLOW;
                S_RED_YELLOW: if (last) state_d = S_GREEN;
                default:      state_d = S_OFF;
            endcase
        end

        // Restart timing on every state entry and while a train holds RED
        if ((state_d != state_q) || (state_q == S_RED && train)) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (state_q == S_YELLOW || state_q == S_RED || state_q == S_RED_YELLOW) begin
            if (tick) begin
                presc_d = '0;
                cnt_d   = cnt_q + CW'(1);
            end else begin
                presc_d = presc_q + CW'(1);
            end
        end

        case (state_d)
            S_GREEN:      lamp_d = 3'b001;
            S_YELLOW:     lamp_d = 3'b010;
            S_RED:        lamp_d = 3'b100;
            S_RED_YELLOW: lamp_d = 3'b110;
            default:      lamp_d = 3'b000;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!clrn) begin
            en_q    <= 1'b0;
            sel_q   <= '0;
            ram_q   <= '{default: '0};
            param_q <= '0;
            presc_q <= '0;
            cnt_q   <= '0;
            state_q <= S_OFF;
            lamp_q  <= 3'b000;
        end else begin
            en_q    <= en_d;
            sel_q   <= sel_d;
            ram_q   <= ram_d;
            param_q <= param_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            lamp_q  <= lamp_d;
        end
    end

    // Register readback; reflects pre-write values within the write cycle
    always_comb begin
        ctl_rddata = '0;
        if (ctl_rd) begin
            if (ctl_addr) begin
                ctl_rddata = {30'b0, sel_q};
            end else begin
                ctl_rddata = {27'b0, lamp_q, 1'b0, en_q};
            end
        end
    end

    assign red    = lamp_q[2];
    assign yellow = lamp_q[1];
    assign green  = lamp_q[0];

endmodule

// File: tb/tb_dec.sv
// Testbench for dec: directed scenarios plus randomized traffic, checked
// against a phase-countdown reference model.
module tb_dec;

    logic        clk;
    logic        clrn;
    logic        ctl_wr;
    logic        ctl_rd;
    logic        ctl_addr;
    logic [31:0] ctl_wrdata;
    logic [31:0] ctl_rddata;
    logic        ram_wr;
    logic [1:0]  ram_addr;
    logic [31:0] ram_wrdata;
    logic        train;
    logic        red;
    logic        yellow;
    logic        green;

    dec u_dec (
        .clk        (clk),
        .clrn       (clrn),
        .ctl_wr     (ctl_wr),
        .ctl_rd     (ctl_rd),
        .ctl_addr   (ctl_addr),
        .ctl_wrdata (ctl_wrdata),
        .ctl_rddata (ctl_rddata),
        .ram_wr     (ram_wr),
        .ram_addr   (ram_addr),
        .ram_wrdata (ram_wrdata),
        .train      (train),
        .red        (red),
        .yellow     (yellow),
        .green      (green)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: each phase holds a countdown of remaining clocks
    typedef enum {M_OFF, M_GRN, M_YEL, M_RED, M_RY} mst_t;
    mst_t        m_st;
    int          m_rem;
    logic        m_en;
    logic [1:0]  m_sel;
    logic [31:0] m_ram [4];
    logic [31:0] m_wp;

    function automatic int dur(input logic [7:0] n, input logic [7:0] p);
        int a;
        int b;
        a = (n == 0) ? 1 : int'(n);
        b = (p == 0) ? 1 : int'(p);
        return a * b;
    endfunction

    function automatic logic [2:0] m_lamps();
        case (m_st)
            M_GRN:   return 3'b001;
            M_YEL:   return 3'b010;
            M_RED:   return 3'b100;
            M_RY:    return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd();
        if (!ctl_rd) return 32'h0;
        if (ctl_addr) return {30'b0, m_sel};
        return {27'b0, m_lamps(), 1'b0, m_en};
    endfunction

    task automatic model_edge();
        mst_t nx;
        if (!clrn) begin
            m_en  = 1'b0;
            m_sel = 2'd0;
            for (int i = 0; i < 4; i++) m_ram[i] = 32'h0;
            m_wp  = 32'h0;
            m_st  = M_OFF;
            m_rem = 0;
            return;
        end
        nx = m_st;
        if (!m_en) begin
            nx = M_OFF;
        end else begin
            case (m_st)
                M_OFF: nx = M_GRN;
                M_GRN: if (train) begin
                    m_wp  = m_ram[m_sel];
                    nx    = M_YEL;
                    m_rem = dur(m_wp[7:0], m_wp[31:24]);
                end
                M_YEL: if (m_rem == 1) begin
                    nx    = M_RED;
                    m_rem = dur(m_wp[15:8], m_wp[31:24]);
                end else m_rem--;
                M_RED: if (train) begin
                    m_rem = dur(m_wp[15:8], m_wp[31:24]);
                end else if (m_rem == 1) begin
                    nx    = M_RY;
                    m_rem = dur(m_wp[23:16], m_wp[31:24]);
                end else m_rem--;
                M_RY: if (m_rem == 1) nx = M_GRN;
                      else m_rem--;
                default: nx = M_OFF;
            endcase
        end
        m_st = nx;
        if (ctl_wr) begin
            if (ctl_addr) m_sel = ctl_wrdata[1:0];
            else          m_en  = ctl_wrdata[0];
        end
        if (ram_wr) m_ram[ram_addr] = ram_wrdata;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("lamps", {29'b0, red, yellow, green}, {29'b0, m_lamps()});
        check("rddata", ctl_rddata, exp_rd());
    endtask

    task automatic ctl_write(input logic a, input logic [31:0] d);
        ctl_wr = 1'b1; ctl_addr = a; ctl_wrdata = d;
        step();
        ctl_wr = 1'b0;
    endtask

    task automatic ram_write(input logic [1:0] a, input logic [31:0] d);
        ram_wr = 1'b1; ram_addr = a; ram_wrdata = d;
        step();
        ram_wr = 1'b0;
    endtask

    // Counts consecutive cycles showing 'lamp'; start = observations already seen
    task automatic run_len(input logic [2:0] lamp, input int start, output int n);
        n = start;
        for (int i = 0; i < 5000; i++) begin
            step();
            if ({red, yellow, green} != lamp) return;
            n++;
        end
    endtask

    task automatic wait_lamp(input logic [2:0] lamp);
        for (int i = 0; i < 5000; i++) begin
            if ({red, yellow, green} == lamp) return;
            step();
        end
        check("wait_timeout", {29'b0, red, yellow, green}, {29'b0, lamp});
    endtask

    int n;

    initial begin
        clrn = 1'b0; ctl_wr = 1'b0; ctl_rd = 1'b0; ctl_addr = 1'b0;
        ctl_wrdata = 32'h0; ram_wr = 1'b0; ram_addr = 2'd0; ram_wrdata = 32'h0;
        train = 1'b0;
        m_st = M_OFF; m_rem = 0; m_en = 1'b0; m_sel = 2'd0; m_wp = 32'h0;
        for (int i = 0; i < 4; i++) m_ram[i] = 32'h0;

        step();
        step();
        check("rst_lamps", {29'b0, red, yellow, green}, 32'h0);
        check("rst_rddata", ctl_rddata, 32'h0);
        clrn = 1'b1;

        // Reset then enable
        ctl_write(1'b0, 32'h1);
        check("en_write_edge", {29'b0, red, yellow, green}, 32'h0);
        step();
        check("en_green", {29'b0, red, yellow, green}, 32'h1);

        // Sequence with SEL=1
        ram_write(2'd1, 32'h0A1E281E);
        ctl_write(1'b1, 32'h1);
        train = 1'b1;
        step();
        for (int i = 0; i < 3; i++) step();
        train = 1'b0;
        run_len(3'b010, 4, n);  check("sel1_yellow", n, 300);
        run_len(3'b100, 1, n);  check("sel1_red", n, 400);
        run_len(3'b110, 1, n);  check("sel1_ry", n, 300);
        check("sel1_green", {29'b0, red, yellow, green}, 32'h1);

        // Sequence with SEL=2
        ram_write(2'd2, 32'h0A1E0A64);
        ctl_write(1'b1, 32'h2);
        train = 1'b1;
        step();
        train = 1'b0;
        run_len(3'b010, 1, n);  check("sel2_yellow", n, 1000);
        run_len(3'b100, 1, n);  check("sel2_red", n, 100);
        run_len(3'b110, 1, n);  check("sel2_ry", n, 300);

        // Red extension: train held through yellow and 50 clocks of red
        train = 1'b1;
        step();
        wait_lamp(3'b100);
        for (int i = 0; i < 49; i++) step();
        train = 1'b0;
        run_len(3'b100, 1, n);  check("ext_red", n, 100);
        run_len(3'b110, 1, n);  check("ext_ry", n, 300);

        // Disable during red
        train = 1'b1;
        step();
        train = 1'b0;
        wait_lamp(3'b100);
        ctl_write(1'b0, 32'h0);
        check("dis_write_edge", {29'b0, red, yellow, green}, 32'h4);
        step();
        check("dis_off", {29'b0, red, yellow, green}, 32'h0);
        ctl_write(1'b0, 32'h1);
        step();
        check("reen_green", {29'b0, red, yellow, green}, 32'h1);
        for (int i = 0; i < 20; i++) step();
        check("no_residual", {29'b0, red, yellow, green}, 32'h1);

        // Readback, including read during a write
        ctl_write(1'b1, 32'h3);
        ctl_rd = 1'b1; ctl_addr = 1'b1;
        #1 check("rd_sel", ctl_rddata, 32'h3);
        ctl_addr = 1'b0;
        #1 check("rd_ctrl", ctl_rddata, 32'h5);
        ctl_addr = 1'b1; ctl_wr = 1'b1; ctl_wrdata = 32'h0;
        #1 check("rd_prewrite", ctl_rddata, 32'h3);
        step();
        ctl_wr = 1'b0;
        #1 check("rd_postwrite", ctl_rddata, 32'h0);
        ctl_rd = 1'b0;
        #1 check("rd_idle", ctl_rddata, 32'h0);
        ctl_write(1'b1, 32'h2);

        // Reset mid-sequence clears everything, including the RAM
        train = 1'b1;
        step();
        train = 1'b0;
        for (int i = 0; i < 30; i++) step();
        clrn = 1'b0;
        step();
        check("rst_mid_lamps", {29'b0, red, yellow, green}, 32'h0);
        clrn = 1'b1;
        ctl_rd = 1'b1; ctl_addr = 1'b1;
        #1 check("rst_mid_sel", ctl_rddata, 32'h0);
        ctl_rd = 1'b0;
        ctl_write(1'b0, 32'h1);
        step();
        train = 1'b1;
        step();
        train = 1'b0;
        run_len(3'b010, 1, n);  check("rst_ram_zero", n, 1);
        for (int i = 0; i < 5; i++) step();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            clrn       = ($urandom_range(0, 599) != 0);
            ctl_wr     = ($urandom_range(0, 39) == 0);
            ctl_addr   = 1'($urandom_range(0, 1));
            ctl_wrdata = $urandom;
            if (ctl_wr && !ctl_addr) ctl_wrdata[0] = ($urandom_range(0, 3) != 0);
            ctl_rd     = 1'($urandom_range(0, 1));
            ram_wr     = ($urandom_range(0, 9) == 0);
            ram_addr   = 2'($urandom_range(0, 3));
            ram_wrdata = $urandom & 32'h0307_0707;
            train      = ($urandom_range(0, 5) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
